// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with optional skid entry, hold/flush
// control and saturating stall/flush statistics.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              Hold,
  input  logic              Flush,
  input  logic              ClrCnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_ent;
  logic   xin;
  logic   xout;
  logic   stall_inc;
  logic   flush_inc;

  assign in_ent = '{ctrl: in_ctrl, data: in_data};

  always_comb begin
    in_ready = 1'b0;
    if (!Flush && !Hold) begin
      if (SKID != 0)
        in_ready = (state != TWO);
      else
        in_ready = (state == EMPTY) || out_ready;
    end
  end

  assign out_valid = ~Flush & ~Hold & (state != EMPTY);
  assign xin       = in_valid & in_ready;
  assign xout      = out_valid & out_ready;
  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;

  always_comb begin
    occupancy = 2'd0;
    unique case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (Flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (!Hold) begin
      unique case (state)
        EMPTY: begin
          if (xin) begin
            state  <= ONE;
            main_q <= in_ent;
          end
        end
        ONE: begin
          if (xin && xout) begin
            main_q <= in_ent;
          end else if (xin) begin
            // Only reachable with a skid entry: in_ready needs out_ready otherwise
            state  <= TWO;
            skid_q <= in_ent;
          end else if (xout) begin
            state  <= EMPTY;
            main_q <= '0;
          end
        end
        TWO: begin
          if (xout) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= '0;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  assign stall_inc = in_valid & ~in_ready & ~Flush;
  assign flush_inc = Flush & ((state != EMPTY) | in_valid);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (ClrCnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DW   = 32;
  localparam int CW   = 11;
  localparam int NW   = 4;
  localparam int MAXC = (1 << NW) - 1;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          Hold;
  logic          Flush;
  logic          ClrCnt;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] flush_cnt;

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .Hold(Hold), .Flush(Flush), .ClrCnt(ClrCnt),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  int   m_stall = 0;
  int   m_flush = 0;
  logic m_rdy;
  logic m_vld;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  // Compare all outputs against the model, shortly after inputs settle
  task automatic settle();
    ent_t h;
    #1;
    m_rdy = !Flush && !Hold && (q.size() < 2);
    m_vld = !Flush && !Hold && (q.size() > 0);
    h = (q.size() > 0) ? q[0] : '0;
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_data", 64'(out_data), 64'(h.d));
    chk("out_ctrl", 64'(out_ctrl), 64'(h.c));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
  endtask

  task automatic tick();
    logic xin;
    logic xout;
    xin  = in_valid && m_rdy;
    xout = m_vld && out_ready;
    @(posedge Clk);
    if (Rst) begin
      model_reset();
    end else begin
      if (ClrCnt) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (in_valid && !m_rdy && !Flush && m_stall < MAXC) m_stall++;
        if (Flush && (q.size() > 0 || in_valid) && m_flush < MAXC) m_flush++;
      end
      if (Flush) begin
        q.delete();
      end else if (!Hold) begin
        if (xout) void'(q.pop_front());
        if (xin) q.push_back('{c: in_ctrl, d: in_data});
      end
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic r);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
  endtask

  initial begin
    Rst = 1'b1;
    Hold = 1'b0;
    Flush = 1'b0;
    ClrCnt = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    model_reset();

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    step();
    step();
    Rst = 1'b0;

    // Single pass
    drive(1'b1, 32'h0040_0004, 11'h123, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b1);
    settle();
    chk("sp_valid", 64'(out_valid), 64'd1);
    chk("sp_data", 64'(out_data), 64'h0040_0004);
    chk("sp_ctrl", 64'(out_ctrl), 64'h123);
    chk("sp_occ", 64'(occupancy), 64'd1);
    tick();

    // Backpressure with skid
    drive(1'b0, '0, '0, 1'b0);
    ClrCnt = 1'b1;
    step();
    ClrCnt = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 11'h0A1, 1'b0);
    step();
    drive(1'b1, 32'hBBBB_0002, 11'h0B2, 1'b0);
    step();
    drive(1'b1, 32'hCCCC_0003, 11'h0C3, 1'b0);
    settle();
    chk("bp_c_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    tick();
    drive(1'b1, 32'hCCCC_0003, 11'h0C3, 1'b1);
    settle();
    chk("bp_stall", 64'(stall_cnt), 64'd1);
    chk("bp_first", 64'(out_data), 64'hAAAA_0001);
    tick();
    settle();
    chk("bp_second", 64'(out_data), 64'hBBBB_0002);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("bp_third", 64'(out_data), 64'hCCCC_0003);
    tick();

    // Hold for three cycles with an offer pending
    ClrCnt = 1'b1;
    step();
    ClrCnt = 1'b0;
    Hold = 1'b1;
    drive(1'b1, 32'hDDDD_0004, 11'h0D4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_valid", 64'(out_valid), 64'd0);
      chk("hold_ready", 64'(in_ready), 64'd0);
      chk("hold_data", 64'(out_data), 64'hCCCC_0003);
      tick();
    end
    Hold = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("hold_stall", 64'(stall_cnt), 64'd3);
    chk("hold_release", 64'(out_data), 64'hCCCC_0003);
    chk("hold_rel_vld", 64'(out_valid), 64'd1);
    tick();

    // Flush wins over Hold
    ClrCnt = 1'b1;
    drive(1'b1, 32'hEEEE_0005, 11'h0E5, 1'b0);
    step();
    ClrCnt = 1'b0;
    Flush = 1'b1;
    Hold = 1'b1;
    drive(1'b1, 32'hFFFF_0006, 11'h0F6, 1'b0);
    settle();
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    tick();
    Flush = 1'b0;
    Hold = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_data", 64'(out_data), 64'd0);
    chk("fl_cnt", 64'(flush_cnt), 64'd1);
    tick();

    // Async reset between edges
    drive(1'b1, 32'h1111_0007, 11'h017, 1'b0);
    step();
    drive(1'b1, 32'h2222_0008, 11'h028, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    settle();
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    #1;
    Rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_data", 64'(out_data), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_fcnt", 64'(flush_cnt), 64'd0);
    chk("ar_scnt", 64'(stall_cnt), 64'd0);
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    step();

    // Counter saturation and clear priority
    drive(1'b1, 32'h3333_0009, 11'h039, 1'b0);
    step();
    step();
    for (int i = 0; i < 20; i++) step();
    settle();
    chk("sat_stall", 64'(stall_cnt), 64'hF);
    ClrCnt = 1'b1;
    tick();
    ClrCnt = 1'b0;
    settle();
    chk("sat_clear", 64'(stall_cnt), 64'd0);
    tick();
    Flush = 1'b1;
    step();
    Flush = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom()),
            11'($urandom()), 1'($urandom_range(0, 1)));
      Hold   = ($urandom_range(0, 99) < 10);
      Flush  = ($urandom_range(0, 99) < 5);
      ClrCnt = ($urandom_range(0, 99) < 3);
      step();
    end
    Hold = 1'b0;
    Flush = 1'b0;
    ClrCnt = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    settle();
    chk("drain_occ", 64'(occupancy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
